// File: rtl/serial_tx_frame_pkg.sv
// Shared definitions for the serial link transmitter: FSM state encodings,
// line levels for idle/start/stop, and a counter-width helper that never
// returns zero (so 1-bit-per-clock and 1-bit-word builds still elaborate).
package serial_tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_BIT = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4
  } state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Width of a counter that must hold 0..n-1; at least one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_frame_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, flagging the last cycle.
// Latency: bit_end is combinational from the counter flop; held at 0 while clr=1.
// Backpressure: none; runs freely whenever clr is low.
// Ports: clk/rst (sync, active-high), clr (synchronous clear), bit_end (tick).
module serial_tx_frame_bit_timer
  import serial_tx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    bit_end = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      bit_end = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_tx_frame.sv
// Frame transmitter: start bit, DATA_W bits LSB-first, optional parity, stop bit.
// Latency: TX/BUSY change one edge after START is accepted; every output is a flop.
// Backpressure: START is taken only while idle; requests during a frame are dropped.
// Ports: CLK, RST (sync, active-high), D (word), START (request),
//        TX (serial line), BUSY (frame in flight), DONE (1-cycle completion pulse).
module serial_tx_frame
  import serial_tx_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] D,
  input  logic              START,
  output logic              TX,
  output logic              BUSY,
  output logic              DONE
);

  localparam int IW = cnt_w(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;

  // Timer is held at zero while idle so the start bit gets a full period
  // counted from the accepting edge.
  serial_tx_frame_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (CLK),
    .rst    (RST),
    .clr    (state_q == ST_IDLE),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d  = ST_START_BIT;
          shift_d  = D;
          idx_d    = '0;
          parity_d = (^D) ^ PARITY_ODD;
        end
      end
      ST_START_BIT: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is derived from the *next* state so TX is registered
    // yet aligned with the state it belongs to.
    case (state_d)
      ST_START_BIT: tx_d = START_LEVEL;
      ST_DATA:      tx_d = shift_d[0];
      ST_PARITY:    tx_d = parity_d;
      ST_STOP:      tx_d = STOP_LEVEL;
      default:      tx_d = LINE_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= LINE_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TX   = tx_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: four builds share one stimulus stream
// (even parity, odd parity, no parity, 1 clock per bit); a selector picks
// which build's outputs are compared against the expected line waveform.
module tb_serial_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] D;
  logic       START;
  logic [3:0] tx_w, busy_w, done_w;
  logic [1:0] sel;
  logic       tx_m, busy_m, done_m;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-build configuration, indexed by sel.
  int cpb_of[4] = '{4, 4, 4, 1};
  int pe_of[4]  = '{1, 1, 0, 1};
  int po_of[4]  = '{0, 1, 0, 0};

  serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .CLK(CLK), .RST(RST), .D(D), .START(START), .TX(tx_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]));
  serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .CLK(CLK), .RST(RST), .D(D), .START(START), .TX(tx_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]));
  serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar (
    .CLK(CLK), .RST(RST), .D(D), .START(START), .TX(tx_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2]));
  serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_c1 (
    .CLK(CLK), .RST(RST), .D(D), .START(START), .TX(tx_w[3]), .BUSY(busy_w[3]), .DONE(done_w[3]));

  always_comb begin
    tx_m   = tx_w[sel];
    busy_m = busy_w[sel];
    done_m = done_w[sel];
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: line bits of a frame as a list, bit n = n-th bit on the wire.
  task automatic build_frame(input logic [7:0] d, input int pe, input int po,
                             output logic [10:0] bits, output int nb);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (pe != 0) begin
      bits[9] = logic'((($countones(d) % 2) + po) % 2);
      nb = 11;
    end else begin
      nb = 10;
    end
    bits[nb-1] = 1'b1;
  endtask

  // START must already be set up so that it is sampled at the next edge (k).
  // Checks every cycle after edges k..k+F-1, then the DONE cycle after k+F.
  task automatic run_frame(input string tag, input logic [10:0] bits, input int nb,
                           input int cpb, input bit hold, input bit chg,
                           input logic [7:0] dnew);
    int f;
    f = nb * cpb;
    for (int j = 0; j < f; j++) begin
      @(negedge CLK);
      if (!hold) START = 1'b0;
      if (chg && j == f / 2) D = dnew;
      chk({tag, " tx"},   tx_m,   bits[j / cpb]);
      chk({tag, " busy"}, busy_m, 1'b1);
      chk({tag, " done"}, done_m, 1'b0);
    end
    @(negedge CLK);
    chk({tag, " end tx"},   tx_m,   1'b1);
    chk({tag, " end busy"}, busy_m, 1'b0);
    chk({tag, " end done"}, done_m, 1'b1);
  endtask

  task automatic settle();
    START = 1'b0;
    repeat (60) @(negedge CLK);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  sel;
    logic [10:0] exp_line;
    int          nbits;
  } vec_t;

  vec_t        tbl[6];
  logic [10:0] bits;
  int          nb;
  logic        seen_done;

  initial begin
    // {stop, parity, data, start} written out by hand.
    tbl[0] = '{8'hA5, 2'd0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11};
    tbl[1] = '{8'h01, 2'd1, {1'b1, 1'b0, 8'h01, 1'b0}, 11};
    tbl[2] = '{8'hA5, 2'd1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11};
    tbl[3] = '{8'h01, 2'd2, {1'b1, 1'b1, 8'h01, 1'b0}, 10};
    tbl[4] = '{8'hA5, 2'd3, {1'b1, 1'b0, 8'hA5, 1'b0}, 11};
    tbl[5] = '{8'h3C, 2'd0, {1'b1, 1'b0, 8'h3C, 1'b0}, 11};

    sel   = 2'd0;
    RST   = 1'b1;
    START = 1'b1;
    D     = 8'hA5;

    // Reset held with START asserted: all builds stay idle.
    repeat (2) begin
      @(negedge CLK);
      for (int s = 0; s < 4; s++) begin
        chk("reset tx",   tx_w[s],   1'b1);
        chk("reset busy", busy_w[s], 1'b0);
        chk("reset done", done_w[s], 1'b0);
      end
    end
    RST   = 1'b0;
    START = 1'b0;
    repeat (3) @(negedge CLK);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      sel   = tbl[v].sel;
      D     = tbl[v].d;
      START = 1'b1;
      run_frame($sformatf("vec%0d", v), tbl[v].exp_line, tbl[v].nbits,
                cpb_of[tbl[v].sel], 1'b0, 1'b0, 8'h00);
      settle();
    end

    // Busy interference: START held, D changes mid-frame, back-to-back frame.
    sel   = 2'd0;
    D     = 8'h3C;
    START = 1'b1;
    build_frame(8'h3C, 1, 0, bits, nb);
    run_frame("hold first", bits, nb, 4, 1'b1, 1'b1, 8'hFF);
    build_frame(8'hFF, 1, 0, bits, nb);
    run_frame("hold second", bits, nb, 4, 1'b0, 1'b0, 8'h00);
    settle();

    // Reset in the middle of the DATA state.
    sel   = 2'd0;
    D     = 8'hA5;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (13) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst tx",   tx_m,   1'b1);
    chk("midrst busy", busy_m, 1'b0);
    chk("midrst done", done_m, 1'b0);
    RST = 1'b0;
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      seen_done = seen_done | done_m;
    end
    chk("midrst no done", seen_done, 1'b0);
    D     = 8'hA5;
    START = 1'b1;
    build_frame(8'hA5, 1, 0, bits, nb);
    run_frame("after rst", bits, nb, 4, 1'b0, 1'b0, 8'h00);
    settle();

    // Random words on random builds, checked against the reference frame.
    for (int r = 0; r < 12; r++) begin
      sel   = 2'($urandom_range(0, 3));
      D     = 8'($urandom);
      START = 1'b1;
      build_frame(D, pe_of[sel], po_of[sel], bits, nb);
      run_frame($sformatf("rnd%0d", r), bits, nb, cpb_of[sel], 1'b0, 1'b0, 8'h00);
      settle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx_frame.md
# serial_tx_frame

Parallel-to-serial frame transmitter: latches a DATA_W-bit word on a start request, then shifts it out LSB-first on a single line as start bit, data bits, optional parity and stop bit, each held for CLKS_PER_BIT clocks. It is the sending end of the team's serial link, paired with the serial receiver/deserializer. It uses the team's registered-output style: every output comes from a flop clocked on CLK.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 4, clocks each line bit is held (≥1)
- PARITY_EN, 1, 1 = insert parity bit after data
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
- CLK  input  1  single clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- D  input  DATA_W  word to send; sampled only on an accepted START
- START  input  1  send request; accepted only when BUSY=0
- TX  output  1  serial line; idle level 1
- BUSY  output  1  frame in progress
- DONE  output  1  one-cycle pulse when a frame completes

## Operation
- Reset values: TX=1, BUSY=0, DONE=0, state IDLE, shift register and counters 0.
- States:
  - IDLE: TX=1.
  - START_BIT: TX=0.
  - DATA: TX = shift-register bit 0, shifted right at the end of each bit.
  - PARITY: TX = XOR(D latched) XOR PARITY_ODD. Skipped when PARITY_EN=0.
  - STOP: TX=1.
- Transitions:
  - IDLE→START_BIT on START=1.
  - START_BIT→DATA.
  - DATA→PARITY after DATA_W bits, or DATA→STOP directly when PARITY_EN=0.
  - PARITY→STOP.
  - STOP→IDLE.
  - Every non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by the bit-cycle counter, which counts 0..CLKS_PER_BIT-1 and wraps.
- Bit index counter: $clog2(DATA_W) bits, counts 0..DATA_W-1 inside DATA.
- D is captured into the shift register on the accepting edge. Later changes to D do not affect the frame in flight.
- START while BUSY=1 is ignored; it is not queued.
- RST has priority over every other input. Mid-frame reset aborts the frame: TX=1 and BUSY=0 at the next edge, and no DONE pulse.

## Timing
- Frame length F = (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles.
- START=1 sampled at edge k (BUSY=0): after edge k, TX=0 and BUSY=1.
- Bit n of the frame (n=0 is the start bit) is driven from edge k+n·CLKS_PER_BIT to edge k+(n+1)·CLKS_PER_BIT.
- At edge k+F: state=IDLE, BUSY=0, DONE=1, TX=1. DONE drops at edge k+F+1 unless a new frame ends there.
- Back-to-back: START=1 in the DONE cycle is accepted at edge k+F+1. TX then goes to 0 with no extra idle time, and BUSY drops for exactly one cycle.
- CLKS_PER_BIT=1: one bit per clock, same state sequence.

## Structure
- Shared package/header serial_defs: state encodings (IDLE, START_BIT, DATA, PARITY, STOP), the line idle level constant (1), and the start/stop level constants.
- Sub-module bit_timer:
  - Parameterised CLKS_PER_BIT counter with synchronous clear.
  - Outputs a one-cycle bit_end tick.
  - Held clear in IDLE.
- Top level holds the FSM, the shift register, the bit index and the parity flop.

## Test plan
Defaults unless stated: DATA_W=8, CLKS_PER_BIT=4.
- Reset: RST=1 for 2 cycles with START=1 → TX=1, BUSY=0, DONE=0 throughout.
- Even parity, D=8'hA5, START pulse → line bits 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles. That is 44 cycles, then DONE=1 for 1 cycle.
- Odd parity, PARITY_ODD=1, D=8'h01 → parity bit 0. With PARITY_EN=0 the frame is 10 bits (40 cycles) with no parity slot.
- Busy interference:
  - START=1 held through a frame sending D=8'h3C, with D changed to 8'hFF mid-frame.
  - Required: the transmitted data is 3C.
  - Required: a second frame starts the cycle after DONE, and its data is FF (D was FF when START was accepted).
  - Required: BUSY is low for exactly 1 cycle between the frames.
- Reset mid-frame: RST=1 during the DATA state of an 8'hA5 frame → TX=1 and BUSY=0 at the next edge, DONE never pulses, and the next START produces a complete, correct frame.
- CLKS_PER_BIT=1, D=8'hA5 → the 11-bit pattern from the even-parity case at 1 bit per clock, with DONE at edge k+11.
